// File: rtl/list_accum.sv
// Linked-list walker: sums or takes the unsigned max of node values
// held in a synchronous RAM, with overflow, node count and a length guard.
module list_accum #(
    parameter int WIDTH     = 8,
    parameter int AW        = 8,
    parameter int MAX_NODES = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [AW-1:0]    head,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_rd,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             err,
    output logic [AW-1:0]    node_count
);

    typedef enum logic [2:0] {IDLE, VADDR, VDATA, NDATA, DONE} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             overflow_q, overflow_d;
    logic             err_q, err_d;
    logic [AW-1:0]    count_q, count_d;
    logic             mem_rd_q, mem_rd_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   sum_w;
    logic [AW-1:0]    cnt_inc;
    logic [AW-1:0]    next_ptr;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        mode_d     = mode_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        err_d      = err_q;
        count_d    = count_q;
        sum_w      = {1'b0, result_q} + {1'b0, mem_rdata};
        cnt_inc    = count_q + AW'(1);
        next_ptr   = mem_rdata[AW-1:0];

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ptr_d      = head;
                    mode_d     = mode;
                    result_d   = '0;
                    overflow_d = 1'b0;
                    err_d      = 1'b0;
                    count_d    = '0;
                    state_d    = VADDR;
                end
            end
            VADDR: state_d = VDATA;
            VDATA: begin
                if (mode_q) begin
                    if (mem_rdata > result_q) result_d = mem_rdata;
                end else begin
                    result_d   = sum_w[WIDTH-1:0];
                    overflow_d = overflow_q | sum_w[WIDTH];
                end
                state_d = NDATA;
            end
            NDATA: begin
                count_d = cnt_inc;
                ptr_d   = next_ptr;
                // a null link wins over the guard on the same node
                if (next_ptr == '0) begin
                    state_d = DONE;
                end else if (cnt_inc == AW'(MAX_NODES)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = VADDR;
                end
            end
            DONE: if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // outputs are registered from the next state
        mem_rd_d   = (state_d == VADDR) || (state_d == VDATA);
        mem_addr_d = '0;
        if (state_d == VADDR) mem_addr_d = ptr_d;
        if (state_d == VDATA) mem_addr_d = ptr_d + AW'(1);
        busy_d = (state_d == VADDR) || (state_d == VDATA) ||
                 (state_d == NDATA);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            mode_q     <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            mode_q     <= mode_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            err_q      <= err_d;
            count_q    <= count_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_rd     = mem_rd_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = result_q;
    assign overflow   = overflow_q;
    assign err        = err_q;
    assign node_count = count_q;

endmodule

// File: tb/tb_list_accum.sv
// Randomised and directed bench for list_accum against a list-walking
// reference model that predicts every output on every cycle.
module tb_list_accum;

    localparam int MN = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mode;
    logic [7:0] head;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_rdata = '0;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       overflow;
    logic       err;
    logic [7:0] node_count;

    always #5 clk = ~clk;

    list_accum #(.WIDTH(8), .AW(8), .MAX_NODES(MN)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .head(head),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .result(result), .overflow(overflow),
        .err(err), .node_count(node_count)
    );

    logic [7:0] mem [256];
    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // expected outputs for the current cycle
    bit         chk_en = 1'b0;
    logic       e_rd, e_busy, e_done, e_ovf, e_err;
    logic [7:0] e_addr, e_result, e_count;

    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_rd", {31'd0, mem_rd}, {31'd0, e_rd});
            check("mem_addr", {24'd0, mem_addr}, {24'd0, e_addr});
            check("busy", {31'd0, busy}, {31'd0, e_busy});
            check("done", {31'd0, done}, {31'd0, e_done});
            check("result", {24'd0, result}, {24'd0, e_result});
            check("overflow", {31'd0, overflow}, {31'd0, e_ovf});
            check("err", {31'd0, err}, {31'd0, e_err});
            check("node_count", {24'd0, node_count}, {24'd0, e_count});
        end
    end

    // reference walk: node addresses and running results after i nodes
    int         n_nodes;
    bit         m_err;
    logic [7:0] m_addr [256];
    logic [7:0] m_acc [257];
    bit         m_ovf [257];

    task automatic walk(input logic [7:0] h, input bit md);
        logic [7:0] p;
        logic [7:0] nxt;
        int         acc;
        bit         ov;
        p = h; acc = 0; ov = 0; n_nodes = 0; m_err = 0;
        m_acc[0] = 0; m_ovf[0] = 0;
        while (1) begin
            m_addr[n_nodes] = p;
            if (md) begin
                if (int'(mem[p]) > acc) acc = int'(mem[p]);
            end else begin
                acc = acc + int'(mem[p]);
                if (acc > 255) begin
                    ov = 1;
                    acc = acc - 256;
                end
            end
            nxt = mem[p + 8'd1];
            n_nodes++;
            m_acc[n_nodes] = acc[7:0];
            m_ovf[n_nodes] = ov;
            if (nxt == 8'd0) break;
            if (n_nodes == MN) begin
                m_err = 1;
                break;
            end
            p = nxt;
        end
    endtask

    task automatic set_zero_exp();
        e_rd = 0; e_addr = 0; e_busy = 0; e_done = 0;
        e_result = 0; e_ovf = 0; e_err = 0; e_count = 0;
    endtask

    // called just after an edge with the DUT idle
    task automatic run(input logic [7:0] h, input bit md,
                       input int abort_j, input int hold);
        int i;
        int ph;
        walk(h, md);
        start = 1; head = h; mode = md;
        @(posedge clk); #1;
        for (int j = 0; j < 3 * n_nodes; j++) begin
            i = j / 3;
            ph = j % 3;
            e_busy = 1; e_done = 0; e_err = 0;
            e_count = 8'(i);
            e_result = (ph == 2) ? m_acc[i+1] : m_acc[i];
            e_ovf = (ph == 2) ? m_ovf[i+1] : m_ovf[i];
            e_rd = (ph != 2);
            e_addr = (ph == 0) ? m_addr[i] :
                     (ph == 1) ? m_addr[i] + 8'd1 : 8'd0;
            head = 8'($urandom);
            mode = 1'($urandom);
            if (j == abort_j) begin
                rst = 1;
                @(posedge clk); #1;
                set_zero_exp();
                rst = 0;
                return;
            end
            @(posedge clk); #1;
        end
        e_busy = 0; e_done = 1; e_rd = 0; e_addr = 0;
        e_result = m_acc[n_nodes]; e_ovf = m_ovf[n_nodes];
        e_err = m_err; e_count = 8'(n_nodes);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        start = 0;
        @(posedge clk); #1;
        e_done = 0;
        @(posedge clk); #1;
    endtask

    task automatic clear_mem();
        for (int k = 0; k < 256; k++) mem[k] = 8'd0;
    endtask

    task automatic load_list1();
        clear_mem();
        mem[0] = 8'd5;  mem[1] = 8'd4;
        mem[4] = 8'd10; mem[5] = 8'd8;
        mem[8] = 8'd3;  mem[9] = 8'd0;
    endtask

    initial begin
        rst = 1; start = 0; mode = 0; head = 0;
        clear_mem();
        set_zero_exp();
        @(posedge clk); #1;
        chk_en = 1;
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;

        load_list1();
        run(8'd0, 1'b0, -1, 3);
        check("t1_result", {24'd0, result}, 32'd18);
        check("t1_count", {24'd0, node_count}, 32'd3);
        check("t1_ovf", {31'd0, overflow}, 32'd0);
        check("t1_err", {31'd0, err}, 32'd0);

        clear_mem();
        mem[0] = 8'd200; mem[1] = 8'd2; mem[2] = 8'd100; mem[3] = 8'd0;
        run(8'd0, 1'b0, -1, 1);
        check("t2_result", {24'd0, result}, 32'd44);
        check("t2_ovf", {31'd0, overflow}, 32'd1);
        check("t2_count", {24'd0, node_count}, 32'd2);
        load_list1();
        run(8'd0, 1'b0, -1, 0);
        check("t2_rerun_result", {24'd0, result}, 32'd18);
        check("t2_rerun_ovf", {31'd0, overflow}, 32'd0);

        run(8'd0, 1'b1, -1, 2);
        check("t3_max", {24'd0, result}, 32'd10);
        check("t3_ovf", {31'd0, overflow}, 32'd0);

        clear_mem();
        mem[2] = 8'd1; mem[3] = 8'd6; mem[6] = 8'd1; mem[7] = 8'd2;
        run(8'd2, 1'b0, -1, 1);
        check("t4_err", {31'd0, err}, 32'd1);
        check("t4_count", {24'd0, node_count}, 32'd4);
        check("t4_result", {24'd0, result}, 32'd4);

        load_list1();
        run(8'd0, 1'b0, 4, 0);
        check("t5_rst_result", {24'd0, result}, 32'd0);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        run(8'd0, 1'b0, -1, 1);
        check("t5_result", {24'd0, result}, 32'd18);

        clear_mem();
        mem[255] = 8'd7; mem[0] = 8'd0;
        run(8'd255, 1'b0, -1, 0);
        check("t6_result", {24'd0, result}, 32'd7);
        check("t6_count", {24'd0, node_count}, 32'd1);

        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < 256; k++)
                mem[k] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            run(8'($urandom), 1'($urandom),
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 5)) : -1,
                int'($urandom_range(0, 2)));
        end

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
